fwd_hazard_ctrl: RTL
====================

Name: fwd_hazard_ctrl

Overview:
- Forwarding and hazard controller for the 5-stage pipeline.
- Keeps its own shadow copy of the EX/MEM/WB destination-register state and drives the s1/s0 selects of the two EX-stage operand forwarding muxes (operand A, operand B).
- Generates load-use stall, branch-flush and memory-wait freeze controls for PC, IF/ID and ID/EX.
- Sits beside the ID/EX pipeline registers and is fed by decode and EX branch resolution.

Parameters:
- REG_W, 5, register index width.
- CNT_W, 32, statistics counter width (used only with the optional feature).

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  synchronous, active-high reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs1, id_rs2  in  REG_W  ID source registers.
- id_use_rs1, id_use_rs2  in  1  instruction actually reads rs1 / rs2.
- id_rd  in  REG_W  ID destination register.
- id_regwrite  in  1  ID instruction writes rd.
- id_memread  in  1  ID instruction is a load.
- ex_branch_taken  in  1  EX resolved a taken branch/jump.
- mem_wait  in  1  data memory not ready; freeze the whole pipeline.
- fwd_a_s1, fwd_a_s0  out  1  operand-A mux selects.
- fwd_b_s1, fwd_b_s0  out  1  operand-B mux selects.
- pc_stall, ifid_stall  out  1  hold PC / IF/ID.
- ifid_flush, idex_flush  out  1  zero IF/ID / insert bubble in ID/EX.

Behaviour:
- Clock and reset:
  - One clock, clk; reset is synchronous and active-high, port name reset.
  - On reset, every tracked stage (EX, MEM, WB) has valid=0 and all fields 0.
  - All outputs are 0 in the cycle after reset, i.e. selects are {s1,s0}=00 (d0).
- Select encoding, fixed by the datapath mux:
  - 00 or 11 -> d0, the register-file value.
  - 10 -> d1, the EX/MEM result.
  - 01 -> d2, the MEM/WB result.
  - Only 00, 10 and 01 are ever driven.
- Tracked state per stage: valid, rs1, rs2, use_rs1, use_rs2, rd, regwrite, memread. EX, MEM and WB are each registered.
- Advance rule per cycle, in priority order:
  - If mem_wait=1: all stage registers hold. All four control outputs are driven pc_stall=1, ifid_stall=1, ifid_flush=0, idex_flush=0. ex_branch_taken is ignored because EX is frozen and the branch re-presents itself.
  - Else if ex_branch_taken=1: ifid_flush=1 and idex_flush=1. EX<-bubble (valid=0), MEM<-EX, WB<-MEM. Flush beats a simultaneous load-use stall.
  - Else if load-use: pc_stall=1, ifid_stall=1, idex_flush=1. EX<-bubble, MEM<-EX, WB<-MEM.
  - Else: EX<-ID fields (valid=id_valid), MEM<-EX, WB<-MEM.
- Load-use condition (combinational, from ID inputs and registered EX):
  - EX.valid & EX.memread & EX.regwrite & EX.rd!=0, and
  - id_valid & ((id_use_rs1 & id_rs1==EX.rd) | (id_use_rs2 & id_rs2==EX.rd)).
  - Exactly one stall cycle per hazard; on the next cycle the load sits in MEM and is forwarded from WB-side timing.
- Forward select for operand A (same for B using rs2), combinational from registered state:
  - If EX.use_rs1 & MEM.valid & MEM.regwrite & MEM.rd!=0 & MEM.rd==EX.rs1 -> 10.
  - Else if the same test against WB -> 01.
  - Else 00.
  - MEM always has priority over WB.
  - x0 is never forwarded.
  - A load in MEM is never a forward source, because the stall guarantees it has reached WB.
- Selects are 00 whenever EX.valid=0.
- Reset mid-stall or mid-freeze: reset wins, and all state clears in that cycle.

Optional Feature:
- Macro: FWD_HAZARD_STATS_EN.
- When defined, adds three outputs, each CNT_W wide:
  - stat_stall_cnt: cycles with load-use stall.
  - stat_flush_cnt: cycles with branch flush.
  - stat_fwd_cnt: cycles with a nonzero select on A or B.
- Counters are cleared by reset, increment by 1 per qualifying non-mem_wait cycle, and wrap modulo 2^CNT_W.
- When not defined, the ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Package fwd_pkg holds:
  - typedef fwd_sel_e for the 2-bit encodings FWD_RF=2'b00, FWD_EXMEM=2'b10, FWD_MEMWB=2'b01.
  - typedef stage_info_t, the tracked-stage struct.
  - localparam REG_ZERO.
- One sub-module, fwd_sel_logic, is instantiated twice (operands A and B). It maps a source index, its use bit and the MEM/WB info to fwd_sel_e.

Test Plan:
- Back-to-back ALU dependency: add x5 (EX->MEM), then an EX instruction reading rs1=x5 -> fwd_a={1,0}, no stall.
- Distance-2 dependency: x6 written in WB while EX reads rs2=x6 -> fwd_b={0,1}. If MEM also writes x6 -> fwd_b={1,0}.
- Load-use: lw x7 in EX, ID reads x7 -> one cycle of pc_stall=ifid_stall=idex_flush=1. Next cycle: no stall, and fwd selects 01 once the load reaches WB.
- Branch flush vs load-use in the same cycle -> ifid_flush=idex_flush=1, pc_stall=0.
- Writes to x0 in MEM and WB with EX reading x0 -> selects 00. Then mem_wait held 3 cycles -> state frozen, pc_stall=ifid_stall=1, and selects unchanged throughout.
- Reset asserted during a stall -> next cycle all outputs 0. With FWD_HAZARD_STATS_EN defined, all stat counters are 0.

Source files
------------

// File: rtl/fwd_hazard_ctrl_pkg.sv
// fwd_pkg: shared types for the forwarding / hazard controller.
//   fwd_sel_e    - 2-bit operand-mux select {s1,s0} as wired in the datapath
//   stage_info_t - per-stage shadow of the register-usage fields of an instruction
//   REG_ZERO     - index of the hard-wired zero register (never forwarded)
package fwd_pkg;

    localparam int unsigned REG_IDX_W = 5;

    localparam logic [REG_IDX_W-1:0] REG_ZERO = '0;

    // 11 also selects d0 in the mux but is never driven
    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b10,
        FWD_MEMWB = 2'b01
    } fwd_sel_e;

    typedef struct packed {
        logic                 valid;
        logic [REG_IDX_W-1:0] rs1;
        logic [REG_IDX_W-1:0] rs2;
        logic                 use_rs1;
        logic                 use_rs2;
        logic [REG_IDX_W-1:0] rd;
        logic                 regwrite;
        logic                 memread;
    } stage_info_t;

    localparam stage_info_t STAGE_BUBBLE = '0;

endpackage

// File: rtl/fwd_hazard_ctrl_sel_logic.sv
// fwd_sel_logic: forwarding select for one EX operand.
//   src     in  source register index read by the EX instruction
//   use_src in  EX instruction is valid and actually reads src
//   mem     in  shadow of the instruction in MEM
//   wb      in  shadow of the instruction in WB
//   sel     out mux select; MEM result beats WB result, x0 never forwarded
module fwd_sel_logic
    import fwd_pkg::*;
(
    input  logic [REG_IDX_W-1:0] src,
    input  logic                 use_src,
    input  stage_info_t          mem,
    input  stage_info_t          wb,
    output fwd_sel_e             sel
);

    function automatic logic produces(input stage_info_t s, input logic [REG_IDX_W-1:0] idx);
        return s.valid & s.regwrite & (s.rd != REG_ZERO) & (s.rd == idx);
    endfunction

    always_comb begin
        sel = FWD_RF;
        if (use_src && produces(mem, src)) begin
            sel = FWD_EXMEM;
        end else if (use_src && produces(wb, src)) begin
            sel = FWD_MEMWB;
        end
    end

    // Source-side and load fields of the producers play no part in forwarding
    logic unused_fields;
    assign unused_fields = ^{mem.rs1, mem.rs2, mem.use_rs1, mem.use_rs2, mem.memread,
                             wb.rs1, wb.rs2, wb.use_rs1, wb.use_rs2, wb.memread};

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: forwarding and hazard controller for the 5-stage pipeline.
// Shadows EX/MEM/WB register usage, drives the two EX operand forwarding
// selects, and produces load-use stall, branch flush and memory-wait freeze.
// Optional statistics counters are built when FWD_HAZARD_STATS_EN is defined.
//   clk, reset                  clock, synchronous active-high reset
//   id_*                        decoded ID-stage instruction fields
//   ex_branch_taken             EX resolved a taken branch/jump
//   mem_wait                    data memory busy, freeze everything
//   fwd_a_s1/s0, fwd_b_s1/s0    operand A/B mux selects
//   pc_stall, ifid_stall        hold PC / IF/ID
//   ifid_flush, idex_flush      zero IF/ID / bubble into ID/EX
//   stat_*_cnt (optional)       stall / flush / forwarding cycle counters
module fwd_hazard_ctrl
    import fwd_pkg::*;
#(
    parameter int unsigned REG_W = 5,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             ex_branch_taken,
    input  logic             mem_wait,
    output logic             fwd_a_s1,
    output logic             fwd_a_s0,
    output logic             fwd_b_s1,
    output logic             fwd_b_s0,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             idex_flush
`ifdef FWD_HAZARD_STATS_EN
    ,
    output logic [CNT_W-1:0] stat_stall_cnt,
    output logic [CNT_W-1:0] stat_flush_cnt,
    output logic [CNT_W-1:0] stat_fwd_cnt
`endif
);

    stage_info_t id_info;
    stage_info_t ex_q, mem_q, wb_q;
    stage_info_t ex_d, mem_d, wb_d;
    logic        load_use;
    fwd_sel_e    sel_a, sel_b;

    always_comb begin
        id_info = '{valid:    id_valid,
                    rs1:      REG_IDX_W'(id_rs1),
                    rs2:      REG_IDX_W'(id_rs2),
                    use_rs1:  id_use_rs1,
                    use_rs2:  id_use_rs2,
                    rd:       REG_IDX_W'(id_rd),
                    regwrite: id_regwrite,
                    memread:  id_memread};
    end

    // A load in EX whose result the ID instruction needs
    always_comb begin
        load_use = ex_q.valid & ex_q.memread & ex_q.regwrite & (ex_q.rd != REG_ZERO) &
                   id_valid & ((id_use_rs1 & (id_info.rs1 == ex_q.rd)) |
                               (id_use_rs2 & (id_info.rs2 == ex_q.rd)));
    end

    // Next-state and pipeline controls, in priority freeze > flush > stall > advance
    always_comb begin
        ex_d       = ex_q;
        mem_d      = mem_q;
        wb_d       = wb_q;
        pc_stall   = 1'b0;
        ifid_stall = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        if (mem_wait) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
        end else begin
            mem_d = ex_q;
            wb_d  = mem_q;
            if (ex_branch_taken) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                ex_d       = STAGE_BUBBLE;
            end else if (load_use) begin
                pc_stall   = 1'b1;
                ifid_stall = 1'b1;
                idex_flush = 1'b1;
                ex_d       = STAGE_BUBBLE;
            end else begin
                ex_d = id_info;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q  <= STAGE_BUBBLE;
            mem_q <= STAGE_BUBBLE;
            wb_q  <= STAGE_BUBBLE;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    // Gating the use bit with EX valid keeps selects at d0 for a bubble
    fwd_sel_logic u_fwd_a (
        .src     (ex_q.rs1),
        .use_src (ex_q.valid & ex_q.use_rs1),
        .mem     (mem_q),
        .wb      (wb_q),
        .sel     (sel_a)
    );

    fwd_sel_logic u_fwd_b (
        .src     (ex_q.rs2),
        .use_src (ex_q.valid & ex_q.use_rs2),
        .mem     (mem_q),
        .wb      (wb_q),
        .sel     (sel_b)
    );

    assign {fwd_a_s1, fwd_a_s0} = sel_a;
    assign {fwd_b_s1, fwd_b_s0} = sel_b;

`ifdef FWD_HAZARD_STATS_EN
    logic stall_cyc, flush_cyc, fwd_cyc;

    assign stall_cyc = ~mem_wait & ~ex_branch_taken & load_use;
    assign flush_cyc = ~mem_wait & ex_branch_taken;
    assign fwd_cyc   = ~mem_wait & ((sel_a != FWD_RF) | (sel_b != FWD_RF));

    // Free-running event counters, wrap naturally
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_stall_cnt <= '0;
            stat_flush_cnt <= '0;
            stat_fwd_cnt   <= '0;
        end else begin
            stat_stall_cnt <= stat_stall_cnt + CNT_W'(stall_cyc);
            stat_flush_cnt <= stat_flush_cnt + CNT_W'(flush_cyc);
            stat_fwd_cnt   <= stat_fwd_cnt + CNT_W'(fwd_cyc);
        end
    end
`else
    logic [CNT_W-1:0] unused_cnt_w;
    assign unused_cnt_w = '0;
`endif

endmodule
